multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 26-bit core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, instruction classes
// and the latched control fields pulled from the instruction word.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        ERR
    } ctrl_state_t;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_MEM   = 2'b10;
    localparam logic [1:0] CLS_BR    = 2'b11;

    localparam int INSTR_W = 26;

    // Fields captured into the IR at fetch; every output decodes from these.
    typedef struct packed {
        logic [1:0] cls;
        logic       mode;
        logic       st;
    } ctrl_fields_t;

    function automatic ctrl_fields_t extract_fields(input logic [INSTR_W-1:0] word);
        ctrl_fields_t f;
        f.cls  = word[25:24];
        f.mode = word[23];
        f.st   = word[22];
        return f;
    endfunction

    // Arith and logic classes both write back an ALU result.
    function automatic logic is_alu_class(input logic [1:0] cls);
        return (cls == CLS_ARITH) || (cls == CLS_LOGIC);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expire marks the last
// cycle allowed before the sequencer gives up with a timeout.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    localparam int W      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + W'(1);
        end
    end

    // count holds completed wait cycles, so TIMEOUT-1 means this is cycle TIMEOUT.
    assign expire = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the PC, IR, ALU, register-file and data-memory controls.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [INSTR_W-1:0]       instr,
    input  logic                     imem_valid,
    input  logic                     mem_ack,
    input  logic                     cmp_true,
    output logic                     imem_req,
    output logic                     ir_load,
    output logic                     alu_imm_sel,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic                     rf_we,
    output logic                     pc_en,
    output logic                     pc_sel_br,
    output logic                     busy,
    output logic                     err_timeout,
    output logic [CNT_W-1:0]         retired_cnt
);

    ctrl_state_t  state;
    ctrl_state_t  next_state;
    ctrl_fields_t fields;
    logic         retire;
    logic         wait_expire;

    // Only the class/mode/store bits steer the sequencer; operands belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[21:0];

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != MEM),
        .enable (state == MEM),
        .expire (wait_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fields      <= '0;
            retired_cnt <= '0;
        end else begin
            state <= next_state;
            if (ir_load) begin
                fields <= extract_fields(instr);
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        alu_imm_sel = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_en       = 1'b0;
        pc_sel_br   = 1'b0;
        err_timeout = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_load    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = EXEC;
            end
            EXEC: begin
                unique case (fields.cls)
                    CLS_ARITH, CLS_LOGIC: begin
                        alu_imm_sel = fields.mode;
                        next_state  = WB;
                    end
                    CLS_MEM: begin
                        next_state = MEM;
                    end
                    CLS_BR: begin
                        pc_en     = 1'b1;
                        pc_sel_br = fields.mode | cmp_true;
                        retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = fields.st;
                // An ack on the expiring cycle still completes the access.
                if (mem_ack) begin
                    if (fields.st) begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        next_state = WB;
                    end
                end else if (wait_expire) begin
                    next_state = ERR;
                end
            end
            WB: begin
                rf_we       = 1'b1;
                pc_en       = 1'b1;
                alu_imm_sel = fields.mode & is_alu_class(fields.cls);
                retire      = 1'b1;
            end
            ERR: begin
                err_timeout = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (retire) begin
            next_state = stop ? IDLE : FETCH;
        end

        busy = (state != IDLE) && (state != ERR);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second instance with a 2-bit counter
// shares the stimulus so counter wrap-around is reachable in a short run.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [25:0] instr;
    logic        imem_valid;
    logic        mem_ack;
    logic        cmp_true;

    logic        imem_req, ir_load, alu_imm_sel, dmem_req, dmem_we;
    logic        rf_we, pc_en, pc_sel_br, busy, err_timeout;
    logic [15:0] retired_cnt;

    logic        w_imem_req, w_ir_load, w_alu_imm_sel, w_dmem_req, w_dmem_we;
    logic        w_rf_we, w_pc_en, w_pc_sel_br, w_busy, w_err_timeout;
    logic [1:0]  w_retired_cnt;

    logic [9:0]  outs;
    logic [9:0]  w_outs;

    int total = 0;
    int bad   = 0;

    // Bit order: imem_req ir_load alu_imm_sel dmem_req dmem_we rf_we pc_en pc_sel_br busy err_timeout
    localparam logic [9:0] O_IDLE       = 10'b0000000000;
    localparam logic [9:0] O_FETCH      = 10'b1000000010;
    localparam logic [9:0] O_FETCH_LD   = 10'b1100000010;
    localparam logic [9:0] O_BUSY       = 10'b0000000010;
    localparam logic [9:0] O_EXEC_IMM   = 10'b0010000010;
    localparam logic [9:0] O_WB_IMM     = 10'b0010011010;
    localparam logic [9:0] O_WB         = 10'b0000011010;
    localparam logic [9:0] O_MEM_LD     = 10'b0001000010;
    localparam logic [9:0] O_MEM_ST     = 10'b0001100010;
    localparam logic [9:0] O_MEM_ST_ACK = 10'b0001101010;
    localparam logic [9:0] O_BR         = 10'b0000001010;
    localparam logic [9:0] O_BR_TAKEN   = 10'b0000001110;
    localparam logic [9:0] O_ERR        = 10'b0000000001;

    localparam logic [25:0] I_ADD_IMM = 26'h0800000;
    localparam logic [25:0] I_LOGIC   = 26'h1000000;
    localparam logic [25:0] I_LOAD    = 26'h2000000;
    localparam logic [25:0] I_STORE   = 26'h2400000;
    localparam logic [25:0] I_BR      = 26'h3000000;
    localparam logic [25:0] I_BR_ALW  = 26'h3800000;

    always #5 clk = ~clk;

    assign outs   = {imem_req, ir_load, alu_imm_sel, dmem_req, dmem_we,
                     rf_we, pc_en, pc_sel_br, busy, err_timeout};
    assign w_outs = {w_imem_req, w_ir_load, w_alu_imm_sel, w_dmem_req, w_dmem_we,
                     w_rf_we, w_pc_en, w_pc_sel_br, w_busy, w_err_timeout};

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .instr       (instr),
        .imem_valid  (imem_valid),
        .mem_ack     (mem_ack),
        .cmp_true    (cmp_true),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .alu_imm_sel (alu_imm_sel),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .pc_en       (pc_en),
        .pc_sel_br   (pc_sel_br),
        .busy        (busy),
        .err_timeout (err_timeout),
        .retired_cnt (retired_cnt)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .instr       (instr),
        .imem_valid  (imem_valid),
        .mem_ack     (mem_ack),
        .cmp_true    (cmp_true),
        .imem_req    (w_imem_req),
        .ir_load     (w_ir_load),
        .alu_imm_sel (w_alu_imm_sel),
        .dmem_req    (w_dmem_req),
        .dmem_we     (w_dmem_we),
        .rf_we       (w_rf_we),
        .pc_en       (w_pc_en),
        .pc_sel_br   (w_pc_sel_br),
        .busy        (w_busy),
        .err_timeout (w_err_timeout),
        .retired_cnt (w_retired_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_outs(input string tag, input logic [9:0] expected);
        check(tag, {22'd0, outs}, {22'd0, expected});
        check({tag, "_w"}, {22'd0, w_outs}, {22'd0, expected});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; instr = '0;
        imem_valid = 1'b0; mem_ack = 1'b0; cmp_true = 1'b0;
        #1;
        check_outs("reset_outs", O_IDLE);
        check("reset_cnt", 32'(retired_cnt), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1 check_outs("idle", O_IDLE);

        // Arith with immediate: c1 FETCH, c2 DECODE, c3 EXEC, c4 WB.
        instr = I_ADD_IMM; start = 1'b1;
        #1 check_outs("idle_start", O_IDLE);
        tick(); start = 1'b0; imem_valid = 1'b1;
        #1 check_outs("t1_fetch", O_FETCH_LD);
        tick(); instr = 26'h3FFFFFF;
        #1 check_outs("t1_decode", O_BUSY);
        tick(); imem_valid = 1'b0; cmp_true = 1'b1;
        #1 check_outs("t1_exec", O_EXEC_IMM);
        tick(); cmp_true = 1'b0;
        #1 check_outs("t1_wb", O_WB_IMM);
        check("t1_cnt_pre", 32'(retired_cnt), 32'd0);
        tick();
        #1 check_outs("t1_next_fetch", O_FETCH);
        check("t1_cnt", 32'(retired_cnt), 32'd1);

        // Load, ack on the third MEM cycle; stray stop/ack before MEM are ignored.
        instr = I_LOAD; imem_valid = 1'b1;
        #1 check_outs("t2_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0; instr = 26'h3FFFFFF; stop = 1'b1; mem_ack = 1'b1;
        #1 check_outs("t2_decode", O_BUSY);
        tick(); stop = 1'b0; mem_ack = 1'b0;
        #1 check_outs("t2_exec", O_BUSY);
        tick();
        #1 check_outs("t2_mem1", O_MEM_LD);
        tick();
        #1 check_outs("t2_mem2", O_MEM_LD);
        tick(); mem_ack = 1'b1;
        #1 check_outs("t2_mem3", O_MEM_LD);
        tick(); mem_ack = 1'b0;
        #1 check_outs("t2_wb", O_WB);
        check("t2_cnt_pre", 32'(retired_cnt), 32'd1);
        tick();
        #1 check_outs("t2_next_fetch", O_FETCH);
        check("t2_cnt", 32'(retired_cnt), 32'd2);

        // Store acked on the first MEM cycle retires there.
        instr = I_STORE; imem_valid = 1'b1;
        #1 check_outs("t3_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0; instr = '0;
        #1 check_outs("t3_decode", O_BUSY);
        tick();
        #1 check_outs("t3_exec", O_BUSY);
        tick(); mem_ack = 1'b1;
        #1 check_outs("t3_mem1", O_MEM_ST_ACK);
        tick(); mem_ack = 1'b0;
        #1 check_outs("t3_next_fetch", O_FETCH);
        check("t3_cnt", 32'(retired_cnt), 32'd3);
        check("t3_wcnt", 32'(w_retired_cnt), 32'd3);

        // Branches: not taken, taken by compare, always-taken mode with stop.
        instr = I_BR; imem_valid = 1'b1;
        #1 check_outs("t4a_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t4a_decode", O_BUSY);
        tick(); cmp_true = 1'b0;
        #1 check_outs("t4a_exec", O_BR);
        tick();
        #1 check_outs("t4a_next_fetch", O_FETCH);
        check("t4a_cnt", 32'(retired_cnt), 32'd4);
        check("t4a_wcnt_wrap", 32'(w_retired_cnt), 32'd0);
        imem_valid = 1'b1;
        #1 check_outs("t4b_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t4b_decode", O_BUSY);
        tick(); cmp_true = 1'b1;
        #1 check_outs("t4b_exec", O_BR_TAKEN);
        tick(); cmp_true = 1'b0; instr = I_BR_ALW; imem_valid = 1'b1;
        #1 check_outs("t4c_fetch", O_FETCH_LD);
        check("t4b_cnt", 32'(retired_cnt), 32'd5);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t4c_decode", O_BUSY);
        tick(); stop = 1'b1;
        #1 check_outs("t4c_exec", O_BR_TAKEN);
        tick(); stop = 1'b0;
        #1 check_outs("t4c_stop_idle", O_IDLE);
        check("t4c_cnt", 32'(retired_cnt), 32'd6);
        tick();
        #1 check_outs("t4c_idle_hold", O_IDLE);

        // Load acked on MEM cycle 4 (the timeout cycle) completes without error.
        instr = I_LOAD; start = 1'b1;
        tick(); start = 1'b0; imem_valid = 1'b1;
        #1 check_outs("t5b_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t5b_decode", O_BUSY);
        tick();
        #1 check_outs("t5b_exec", O_BUSY);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1 check_outs($sformatf("t5b_mem%0d", i), O_MEM_LD);
        end
        tick(); mem_ack = 1'b1;
        #1 check_outs("t5b_mem4", O_MEM_LD);
        tick(); mem_ack = 1'b0; stop = 1'b1;
        #1 check_outs("t5b_wb", O_WB);
        tick(); stop = 1'b0;
        #1 check_outs("t5b_idle", O_IDLE);
        check("t5b_cnt", 32'(retired_cnt), 32'd7);

        // Load with no ack times out after 4 MEM cycles; error is sticky.
        start = 1'b1;
        tick(); start = 1'b0; imem_valid = 1'b1;
        #1 check_outs("t5a_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t5a_decode", O_BUSY);
        tick();
        #1 check_outs("t5a_exec", O_BUSY);
        for (int i = 1; i <= 4; i++) begin
            tick();
            #1 check_outs($sformatf("t5a_mem%0d", i), O_MEM_LD);
        end
        tick();
        #1 check_outs("t5a_err", O_ERR);
        start = 1'b1; imem_valid = 1'b1; mem_ack = 1'b1;
        tick(); tick();
        #1 check_outs("t5a_err_sticky", O_ERR);
        check("t5a_cnt", 32'(retired_cnt), 32'd7);
        start = 1'b0; imem_valid = 1'b0; mem_ack = 1'b0;

        // Reset clears ERR and the counter without waiting for a clock edge.
        tick(); rst = 1'b1;
        #1 check_outs("t6_rst_from_err", O_IDLE);
        check("t6_rst_cnt", 32'(retired_cnt), 32'd0);

        // Reset asserted mid-MEM of a store.
        tick(); rst = 1'b0; instr = I_STORE; start = 1'b1;
        tick(); start = 1'b0; imem_valid = 1'b1;
        #1 check_outs("t6_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t6_decode", O_BUSY);
        tick();
        #1 check_outs("t6_exec", O_BUSY);
        tick();
        #1 check_outs("t6_mem1", O_MEM_ST);
        #2 rst = 1'b1;
        #1 check_outs("t6_rst_mid_mem", O_IDLE);
        check("t6_rst_mid_cnt", 32'(retired_cnt), 32'd0);

        // Logic class without immediate, stop at retire.
        tick(); rst = 1'b0; instr = I_LOGIC; start = 1'b1;
        tick(); start = 1'b0; imem_valid = 1'b1;
        #1 check_outs("t7_fetch", O_FETCH_LD);
        tick(); imem_valid = 1'b0;
        #1 check_outs("t7_decode", O_BUSY);
        tick();
        #1 check_outs("t7_exec", O_BUSY);
        tick(); stop = 1'b1;
        #1 check_outs("t7_wb", O_WB);
        tick(); stop = 1'b0;
        #1 check_outs("t7_idle", O_IDLE);
        check("t7_cnt", 32'(retired_cnt), 32'd1);
        check("t7_wcnt", 32'(w_retired_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
